// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite write-side constants and the write FSM state type.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    HAVE_AW,
    HAVE_W,
    COMMIT,
    RESP
  } wr_state_e;

endpackage

// File: rtl/axi4lite_wr_slave_regs_if.sv
// AXI4-Lite write channels (AW/W/B) between a write master and this register slave.
interface axi4lite_wr_slave_regs_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic [STRB_WIDTH-1:0] WSTRB;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  AWREADY, WREADY, BRESP, BVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output AWREADY, WREADY, BRESP, BVALID
  );

endinterface

// File: rtl/axi4lite_wr_regfile.sv
// Register bank: byte-strobe merge into the selected register plus a one-cycle write pulse.
module axi4lite_wr_regfile #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           we_i,
  input  logic [IDX_W-1:0]               idx_i,
  input  logic [DATA_WIDTH-1:0]          data_i,
  input  logic [STRB_WIDTH-1:0]          strb_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q;
  logic [NUM_REGS-1:0]   wr_pulse_d;

  // Merge enabled bytes into the addressed register; pulse only if some byte is written.
  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (we_i && (idx_i == IDX_W'(i))) begin
        wr_pulse_d[i] = |strb_i;
        for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
          if (strb_i[b]) begin
            regs_d[i][b*8 +: 8] = data_i[b*8 +: 8];
          end
        end
      end
    end
  end

  // Bank and pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_pulse_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  assign wr_pulse_o = wr_pulse_q;

endmodule

// File: rtl/axi4lite_wr_slave_regs.sv
// AXI4-Lite write-only slave: independent AW/W capture, address decode, B response per write.
module axi4lite_wr_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned           NUM_REGS   = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                           pclk,
  input  logic                           presetn,
  axi4lite_wr_slave_regs_if.slave        s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int unsigned           ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int unsigned           IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((2 ** ADDR_LSB) - 1);

  wr_state_e             state_q, state_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;

  logic                  aw_hs_c, w_hs_c;
  logic [ADDR_WIDTH-1:0] off_c, idx_full_c;
  logic [IDX_W-1:0]      idx_c;
  logic                  err_c, we_c;

  assign aw_hs_c = s_axi.AWVALID && awready_q;
  assign w_hs_c  = s_axi.WVALID && wready_q;

  // Decode of the buffered address, consumed in COMMIT.
  always_comb begin
    off_c      = awaddr_q - BASE_ADDR;
    idx_full_c = off_c >> ADDR_LSB;
    err_c      = ((off_c & ALIGN_MASK) != '0) || (idx_full_c >= ADDR_WIDTH'(NUM_REGS));
    idx_c      = IDX_W'(idx_full_c);
    we_c       = (state_q == COMMIT) && !err_c;
  end

  // Next state, registered handshake outputs derived from the next state, buffer capture.
  always_comb begin
    state_d  = state_q;
    bresp_d  = bresp_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;

    case (state_q)
      IDLE: begin
        if (aw_hs_c && w_hs_c) state_d = COMMIT;
        else if (aw_hs_c)      state_d = HAVE_AW;
        else if (w_hs_c)       state_d = HAVE_W;
      end
      HAVE_AW: if (w_hs_c)  state_d = COMMIT;
      HAVE_W:  if (aw_hs_c) state_d = COMMIT;
      COMMIT: begin
        state_d = RESP;
        bresp_d = err_c ? RESP_SLVERR : RESP_OKAY;
      end
      RESP:    if (bvalid_q && s_axi.BREADY) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (aw_hs_c) awaddr_d = s_axi.AWADDR;
    if (w_hs_c) begin
      wdata_d = s_axi.WDATA;
      wstrb_d = s_axi.WSTRB;
    end

    awready_d = (state_d == IDLE) || (state_d == HAVE_W);
    wready_d  = (state_d == IDLE) || (state_d == HAVE_AW);
    bvalid_d  = (state_d == RESP);
  end

  // State, handshake outputs and holding buffers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign s_axi.AWREADY = awready_q;
  assign s_axi.WREADY  = wready_q;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = bresp_q;

  axi4lite_wr_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .clk_i      (pclk),
    .rst_ni     (presetn),
    .we_i       (we_c),
    .idx_i      (idx_c),
    .data_i     (wdata_q),
    .strb_i     (wstrb_q),
    .regs_o     (regs_o),
    .wr_pulse_o (wr_pulse_o)
  );

endmodule
